pipe_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the 5-stage MIPS32 pipeline. It tracks destination-register info for the instructions in EX and MEM in a shadow pipeline. From that state and the ID-stage operand fields it drives these outputs:
- the 2-bit operand-mux selects captured by the ID/EX mux-line register;
- stall and bubble controls for PC, IF/ID and ID/EX;
- IF/ID flush on taken branches.

---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_shadow_stage.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared definitions for the pipeline hazard/forwarding controller:
//   forward-mux encodings, the shadow-pipeline entry type, the default
//   register-address width and the producer/consumer match helper.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM_WB  = 2'b01;
  localparam logic [1:0] FWD_EX_MEM  = 2'b10;

  // One in-flight instruction as seen by the hazard logic.
  // An invalid entry is always held as all-zeros.
  typedef struct packed {
    logic                          valid;
    logic [REG_ADDR_W_DEFAULT-1:0] rd;
    logic                          reg_write;
    logic                          mem_read;
  } shadow_entry_t;

  // A producer feeds a consumer operand only when it really writes a
  // non-zero register that the consumer really reads. $0 never matches.
  function automatic logic entry_match(
    input shadow_entry_t                 e,
    input logic [REG_ADDR_W_DEFAULT-1:0] src,
    input logic                          used
  );
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src) && used;
  endfunction

endpackage

// File: rtl/pipe_shadow_stage.sv
// pipe_shadow_stage
//   One entry of the shadow pipeline that mirrors destination-register
//   information for an instruction in EX or MEM.
// Ports:
//   clock      - pipeline clock, rising edge
//   reset_n    - asynchronous active-low reset, clears the entry
//   load       - capture d on the next rising edge
//   invalidate - clear the entry on the next rising edge (wins over load)
//   d          - entry to capture
//   q          - current entry
module pipe_shadow_stage
  import pipe_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic          invalidate,
  input  shadow_entry_t d,
  output shadow_entry_t q
);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (invalidate) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the 5-stage MIPS32 pipeline.
//   Tracks the EX and MEM destination registers in a two-entry shadow
//   pipeline and, combinationally from that state and the ID operand
//   fields, produces stall/bubble/flush controls and operand forward
//   selects for the ID/EX mux-line register.
// Optional feature macro: PIPE_HAZ_STATS_EN adds saturating stall and
//   flush counters (CNT_W parameter, stall_count/flush_count ports).
// Ports:
//   clock, reset_n                 - clock and async active-low reset
//   id_valid, id_rs, id_rt         - ID instruction and source registers
//   id_rs_used, id_rt_used         - which sources are actually read
//   id_rd, id_reg_write, id_mem_read - ID destination info
//   ex_branch_taken                - branch/jump resolved taken in EX
//   stall_id                       - hold PC and IF/ID
//   flush_if_id                    - zero IF/ID
//   bubble_id_ex                   - load a NOP into ID/EX
//   fwd_a_sel, fwd_b_sel           - operand forward selects
//   stall_count, flush_count       - statistics (macro only)
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
`ifdef PIPE_HAZ_STATS_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic                  stall_id,
  output logic                  flush_if_id,
  output logic                  bubble_id_ex,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef PIPE_HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
`endif
);

  shadow_entry_t ex_sh;
  shadow_entry_t mem_sh;
  shadow_entry_t id_entry;
  logic          ex_load_en;

  logic [REG_ADDR_W_DEFAULT-1:0] rs_x;
  logic [REG_ADDR_W_DEFAULT-1:0] rt_x;

  logic ex_match_a, ex_match_b, mem_match_a, mem_match_b;
  logic load_use;

  // mem_read only matters while the load sits in EX.
  logic unused_mem_read;
  assign unused_mem_read = mem_sh.mem_read;

  assign rs_x = REG_ADDR_W_DEFAULT'(id_rs);
  assign rt_x = REG_ADDR_W_DEFAULT'(id_rt);

  always_comb begin
    id_entry           = '0;
    id_entry.valid     = 1'b1;
    id_entry.rd        = REG_ADDR_W_DEFAULT'(id_rd);
    id_entry.reg_write = id_reg_write;
    id_entry.mem_read  = id_mem_read;
  end

  // A bubbled or empty ID slot enters EX as an invalid entry.
  assign ex_load_en = id_valid && !bubble_id_ex;

  pipe_shadow_stage u_ex_sh (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (ex_load_en),
    .invalidate (!ex_load_en),
    .d          (id_entry),
    .q          (ex_sh)
  );

  pipe_shadow_stage u_mem_sh (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (1'b1),
    .invalidate (1'b0),
    .d          (ex_sh),
    .q          (mem_sh)
  );

  assign ex_match_a  = entry_match(ex_sh,  rs_x, id_rs_used);
  assign ex_match_b  = entry_match(ex_sh,  rt_x, id_rt_used);
  assign mem_match_a = entry_match(mem_sh, rs_x, id_rs_used);
  assign mem_match_b = entry_match(mem_sh, rt_x, id_rt_used);

  assign load_use = id_valid && ex_sh.mem_read && (ex_match_a || ex_match_b);

  // Controls are gated during reset so that arbitrary inputs (notably a
  // stray ex_branch_taken) cannot leak through while the pipe is held.
  always_comb begin
    stall_id     = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (reset_n) begin
      if (ex_branch_taken) begin
        flush_if_id  = 1'b1;
        bubble_id_ex = 1'b1;
      end else if (load_use) begin
        stall_id     = 1'b1;
        bubble_id_ex = 1'b1;
      end
    end
  end

  // EX producer is newer than MEM producer, so it wins.
  always_comb begin
    fwd_a_sel = FWD_REGFILE;
    fwd_b_sel = FWD_REGFILE;
    if (!bubble_id_ex) begin
      if (ex_match_a)       fwd_a_sel = FWD_EX_MEM;
      else if (mem_match_a) fwd_a_sel = FWD_MEM_WB;
      if (ex_match_b)       fwd_b_sel = FWD_EX_MEM;
      else if (mem_match_b) fwd_b_sel = FWD_MEM_WB;
    end
  end

`ifdef PIPE_HAZ_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (stall_id && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
      if (flush_if_id && (flush_count != '1))
        flush_count <= flush_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed bench for pipe_hazard_ctrl. Inputs change on the falling
//   edge; combinational outputs are sampled 1 time unit later, and the
//   shadow pipeline advances on the rising edge in between.
//   Control vector layout: {stall_id, flush_if_id, bubble_id_ex,
//   fwd_a_sel[1:0], fwd_b_sel[1:0]}.
module tb_pipe_hazard_ctrl;

  logic       clock;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       ex_branch_taken;
  logic       stall_id;
  logic       flush_if_id;
  logic       bubble_id_ex;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
`ifdef PIPE_HAZ_STATS_EN
  logic [15:0] stall_count;
  logic [15:0] flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .id_rd           (id_rd),
    .id_reg_write    (id_reg_write),
    .id_mem_read     (id_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .stall_id        (stall_id),
    .flush_if_id     (flush_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel)
`ifdef PIPE_HAZ_STATS_EN
    ,
    .stall_count     (stall_count),
    .flush_count     (flush_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic present(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic rs_u, input logic rt_u, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic taken);
    id_valid        = v;
    id_rs           = rs;
    id_rt           = rt;
    id_rs_used      = rs_u;
    id_rt_used      = rt_u;
    id_rd           = rd;
    id_reg_write    = rw;
    id_mem_read     = mr;
    ex_branch_taken = taken;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    present(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    repeat (n) step();
  endtask

  function automatic logic [6:0] ctrl_vec();
    return {stall_id, flush_if_id, bubble_id_ex, fwd_a_sel, fwd_b_sel};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    present(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
    repeat (3) step();
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want %b", ctrl_vec(), 7'b0000000);
    end
`ifdef PIPE_HAZ_STATS_EN
    n_checks++;
    if (stall_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_count);
    end
    n_checks++;
    if (flush_count !== 16'd0) begin
      n_fail++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_count);
    end
`endif
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_fwd_ex();
    // add $3,$1,$2 is the first instruction after reset release
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL first_after_reset: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
    // sub $4,$3,$7
    present(1'b1, 5'd3, 5'd7, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_10_00) begin
      n_fail++; $display("FAIL fwd_a_ex_mem: got %b want %b", ctrl_vec(), 7'b0001000);
    end
    step();
  endtask

  task automatic test_fwd_mem();
    idle(2);
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL unrelated_between: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
    present(1'b1, 5'd6, 5'd4, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_01) begin
      n_fail++; $display("FAIL fwd_b_mem_wb: got %b want %b", ctrl_vec(), 7'b0000001);
    end
    step();
    // two producers of $4 in a row: EX copy must win
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd6, 5'd4, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_10) begin
      n_fail++; $display("FAIL fwd_b_ex_priority: got %b want %b", ctrl_vec(), 7'b0000010);
    end
    present(1'b1, 5'd4, 5'd4, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_10_10) begin
      n_fail++; $display("FAIL fwd_ab_ex: got %b want %b", ctrl_vec(), 7'b0001010);
    end
    step();
  endtask

  task automatic test_load_use();
    idle(2);
    // lw $5
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    // add $8,$5,$6
    present(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b101_00_00) begin
      n_fail++; $display("FAIL load_use_stall: got %b want %b", ctrl_vec(), 7'b1010000);
    end
    step();
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_01_00) begin
      n_fail++; $display("FAIL load_use_release: got %b want %b", ctrl_vec(), 7'b0000100);
    end
`ifdef PIPE_HAZ_STATS_EN
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_cnt_one: got %0d want 1", stall_count);
    end
    n_checks++;
    if (flush_count !== 16'd0) begin
      n_fail++; $display("FAIL flush_cnt_zero: got %0d want 0", flush_count);
    end
`endif
    step();
  endtask

  task automatic test_flush_priority();
    idle(2);
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0);
    step();
    present(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b011_00_00) begin
      n_fail++; $display("FAIL flush_over_load_use: got %b want %b", ctrl_vec(), 7'b0110000);
    end
    step();
    // load now in MEM, EX holds the bubble: forward, no stall
    present(1'b1, 5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_01_00) begin
      n_fail++; $display("FAIL after_flush_fwd: got %b want %b", ctrl_vec(), 7'b0000100);
    end
`ifdef PIPE_HAZ_STATS_EN
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_cnt_unchanged: got %0d want 1", stall_count);
    end
    n_checks++;
    if (flush_count !== 16'd1) begin
      n_fail++; $display("FAIL flush_cnt_one: got %0d want 1", flush_count);
    end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    idle(2);
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b1);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b011_00_00) begin
      n_fail++; $display("FAIL b2b_flush_1: got %b want %b", ctrl_vec(), 7'b0110000);
    end
    step();
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b011_00_00) begin
      n_fail++; $display("FAIL b2b_flush_2: got %b want %b", ctrl_vec(), 7'b0110000);
    end
    step();
    ex_branch_taken = 1'b0;
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL b2b_after: got %b want %b", ctrl_vec(), 7'b0000000);
    end
`ifdef PIPE_HAZ_STATS_EN
    n_checks++;
    if (flush_count !== 16'd3) begin
      n_fail++; $display("FAIL flush_cnt_three: got %0d want 3", flush_count);
    end
    n_checks++;
    if (stall_count !== 16'd1) begin
      n_fail++; $display("FAIL stall_cnt_still_one: got %0d want 1", stall_count);
    end
`endif
    step();
  endtask

  task automatic test_reg_zero();
    idle(2);
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL r0_no_fwd: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
    // lw $0 then a reader of $0: no load-use stall either
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    step();
    present(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL r0_no_stall: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
  endtask

  task automatic test_no_match();
    idle(2);
    // producer does not write the register file
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd10, 5'd2, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL no_reg_write: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
    // producer slot not valid
    present(1'b0, 5'd1, 5'd2, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
    step();
    present(1'b1, 5'd3, 5'd11, 1'b1, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL invalid_producer: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    step();
    // load producer, consumer does not read its named sources
    present(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 1'b0);
    step();
    present(1'b1, 5'd12, 5'd12, 1'b0, 1'b0, 5'd13, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b000_00_00) begin
      n_fail++; $display("FAIL source_unused: got %b want %b", ctrl_vec(), 7'b0000000);
    end
    // same load, only rt read: now a real load-use hazard
    present(1'b1, 5'd12, 5'd12, 1'b0, 1'b1, 5'd13, 1'b0, 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ctrl_vec() !== 7'b101_00_00) begin
      n_fail++; $display("FAIL rt_only_load_use: got %b want %b", ctrl_vec(), 7'b1010000);
    end
    step();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_fwd_ex();
    test_fwd_mem();
    test_load_use();
    test_flush_priority();
    test_back_to_back();
    test_reg_zero();
    test_no_match();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
